// File: rtl/mips_branch_pkg.sv
// Shared definitions for the MEM-stage branch resolution unit:
// branch kind codes, squash FSM states and a counter-width helper.
package mips_branch_pkg;

    localparam logic [2:0] BR_EQ     = 3'd0;
    localparam logic [2:0] BR_NE     = 3'd1;
    localparam logic [2:0] BR_LEZ    = 3'd2;
    localparam logic [2:0] BR_GTZ    = 3'd3;
    localparam logic [2:0] BR_LTZ    = 3'd4;
    localparam logic [2:0] BR_GEZ    = 3'd5;
    localparam logic [2:0] BR_ALWAYS = 3'd6;
    localparam logic [2:0] BR_RSVD   = 3'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } sq_state_e;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_branch_resolve_if.sv
// Bus between the EX/MEM register, the branch resolution unit and the
// IF-stage PC mux / flush controls.
interface mem_branch_resolve_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STAT_W = 16
);
    logic              m_valid;
    logic              m_ctlout;
    logic [2:0]        br_type;
    logic              zero;
    logic              sign;
    logic [ADDR_W-1:0] target;
    logic              stall;

    logic              PCSrc;
    logic [ADDR_W-1:0] pc_target;
    logic              flush;
    logic              illegal_br;
    logic [STAT_W-1:0] br_resolved;
    logic [STAT_W-1:0] br_taken;

    modport master (
        output m_valid, m_ctlout, br_type, zero, sign, target, stall,
        input  PCSrc, pc_target, flush, illegal_br, br_resolved, br_taken
    );

    modport slave (
        input  m_valid, m_ctlout, br_type, zero, sign, target, stall,
        output PCSrc, pc_target, flush, illegal_br, br_resolved, br_taken
    );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition decode from ALU flags; flags reserved
// codes (or, in legacy mode, anything other than BR_EQ) as illegal.
module branch_cond
    import mips_branch_pkg::*;
#(
    parameter bit EXT_BRANCH = 1'b1
) (
    input  logic [2:0] br_type,
    input  logic       zero,
    input  logic       sign,
    output logic       cond,
    output logic       illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        if (EXT_BRANCH) begin
            case (br_type)
                BR_EQ:     cond = zero;
                BR_NE:     cond = ~zero;
                BR_LEZ:    cond = sign | zero;
                BR_GTZ:    cond = ~sign & ~zero;
                BR_LTZ:    cond = sign;
                BR_GEZ:    cond = ~sign;
                BR_ALWAYS: cond = 1'b1;
                BR_RSVD:   illegal = 1'b1;
                default:   cond = 1'b0;
            endcase
        end else begin
            cond    = (br_type == BR_EQ) & zero;
            illegal = (br_type != BR_EQ);
        end
    end

endmodule

// File: rtl/mem_branch_resolve.sv
// MEM-stage branch resolution: registered redirect, squash FSM covering
// the wrong-path slots, sticky illegal flag and saturating statistics.
module mem_branch_resolve
    import mips_branch_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_STAGES = 3,
    parameter bit          EXT_BRANCH   = 1'b1,
    parameter int unsigned STAT_W       = 16
) (
    input logic             clk,
    input logic             rst_n,
    mem_branch_resolve_if.slave bus
);

    localparam int unsigned      CNT_W    = cnt_width(FLUSH_STAGES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_STAGES - 1);

    sq_state_e         state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              cond, illegal;
    logic              resolve, take;

    logic              pcsrc_q;
    logic [ADDR_W-1:0] pc_target_q;
    logic              illegal_q;
    logic [STAT_W-1:0] resolved_q;
    logic [STAT_W-1:0] taken_q;

    branch_cond #(
        .EXT_BRANCH(EXT_BRANCH)
    ) u_cond (
        .br_type (bus.br_type),
        .zero    (bus.zero),
        .sign    (bus.sign),
        .cond    (cond),
        .illegal (illegal)
    );

    // Only an unstalled, valid branch seen while not squashing is on the true path.
    assign resolve = bus.m_valid & bus.m_ctlout & ~bus.stall & (state == IDLE);
    assign take    = resolve & cond;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nx = SQUASH;
                    cnt_nx   = CNT_INIT;
                end
            end
            SQUASH: begin
                if (!bus.stall) begin
                    if (cnt == '0) state_nx = IDLE;
                    else           cnt_nx   = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcsrc_q     <= 1'b0;
            pc_target_q <= '0;
        end else begin
            pcsrc_q <= take;
            if (take) pc_target_q <= bus.target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q  <= 1'b0;
            resolved_q <= '0;
            taken_q    <= '0;
        end else begin
            if (resolve && illegal) illegal_q <= 1'b1;
            if (resolve && !(&resolved_q)) resolved_q <= resolved_q + 1'b1;
            if (take && !(&taken_q)) taken_q <= taken_q + 1'b1;
        end
    end

    assign bus.PCSrc       = pcsrc_q;
    assign bus.pc_target   = pc_target_q;
    assign bus.flush       = (state == SQUASH);
    assign bus.illegal_br  = illegal_q;
    assign bus.br_resolved = resolved_q;
    assign bus.br_taken    = taken_q;

endmodule

// File: tb/tb_mem_branch_resolve.sv
// Bench for mem_branch_resolve: an extended-mode instance and a legacy
// narrow-stats instance driven in lockstep against a behavioural model.
module tb_mem_branch_resolve;
    import mips_branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_valid = 1'b0, m_ctlout = 1'b0, zero = 1'b0, sign = 1'b0, stall = 1'b0;
    logic [2:0]  br_type = '0;
    logic [31:0] target = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_branch_resolve_if #(.ADDR_W(32), .STAT_W(16)) bus_a ();
    mem_branch_resolve_if #(.ADDR_W(32), .STAT_W(2))  bus_b ();

    assign bus_a.m_valid = m_valid;  assign bus_b.m_valid = m_valid;
    assign bus_a.m_ctlout = m_ctlout; assign bus_b.m_ctlout = m_ctlout;
    assign bus_a.br_type = br_type;  assign bus_b.br_type = br_type;
    assign bus_a.zero = zero;        assign bus_b.zero = zero;
    assign bus_a.sign = sign;        assign bus_b.sign = sign;
    assign bus_a.target = target;    assign bus_b.target = target;
    assign bus_a.stall = stall;      assign bus_b.stall = stall;

    mem_branch_resolve #(
        .ADDR_W(32), .FLUSH_STAGES(3), .EXT_BRANCH(1'b1), .STAT_W(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    mem_branch_resolve #(
        .ADDR_W(32), .FLUSH_STAGES(1), .EXT_BRANCH(1'b0), .STAT_W(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Reference model: remaining squash slots as a plain count.
    typedef struct {
        int          left;
        bit          pcsrc;
        logic [31:0] tgt;
        bit          ill;
        int          res;
        int          tk;
    } mdl_t;

    mdl_t m [2];
    int   flush_n [2] = '{3, 1};
    bit   ext     [2] = '{1'b1, 1'b0};
    int   smax    [2] = '{65535, 3};

    function automatic void eval_br(input bit e, input logic [2:0] bt, input bit z, input bit s,
                                    output bit c, output bit ill);
        if (!e) begin
            c   = (bt == BR_EQ) && z;
            ill = (bt != BR_EQ);
        end else begin
            ill = (bt == BR_RSVD);
            case (bt)
                BR_EQ:     c = z;
                BR_NE:     c = !z;
                BR_LEZ:    c = s || z;
                BR_GTZ:    c = !s && !z;
                BR_LTZ:    c = s;
                BR_GEZ:    c = !s;
                BR_ALWAYS: c = 1'b1;
                default:   c = 1'b0;
            endcase
        end
    endfunction

    task automatic model_edge(input int i);
        bit busy, res, c, ill, tk;
        if (!rst_n) begin
            m[i] = '{0, 1'b0, 32'h0, 1'b0, 0, 0};
            return;
        end
        busy = (m[i].left > 0);
        res  = m_valid && m_ctlout && !stall && !busy;
        eval_br(ext[i], br_type, zero, sign, c, ill);
        tk   = res && c;
        m[i].pcsrc = tk;
        if (tk) m[i].tgt = target;
        if (busy && !stall) m[i].left--;
        if (tk) m[i].left = flush_n[i];
        if (res) begin
            if (m[i].res < smax[i]) m[i].res++;
            if (ill) m[i].ill = 1'b1;
        end
        if (tk && m[i].tk < smax[i]) m[i].tk++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("A.PCSrc",       64'(bus_a.PCSrc),       64'(m[0].pcsrc));
        check("A.pc_target",   64'(bus_a.pc_target),   64'(m[0].tgt));
        check("A.flush",       64'(bus_a.flush),       64'(m[0].left > 0));
        check("A.illegal_br",  64'(bus_a.illegal_br),  64'(m[0].ill));
        check("A.br_resolved", 64'(bus_a.br_resolved), 64'(m[0].res));
        check("A.br_taken",    64'(bus_a.br_taken),    64'(m[0].tk));
        check("B.PCSrc",       64'(bus_b.PCSrc),       64'(m[1].pcsrc));
        check("B.pc_target",   64'(bus_b.pc_target),   64'(m[1].tgt));
        check("B.flush",       64'(bus_b.flush),       64'(m[1].left > 0));
        check("B.illegal_br",  64'(bus_b.illegal_br),  64'(m[1].ill));
        check("B.br_resolved", 64'(bus_b.br_resolved), 64'(m[1].res));
        check("B.br_taken",    64'(bus_b.br_taken),    64'(m[1].tk));
    endtask

    // One clock: apply inputs, clock, advance model, compare #1 after the edge.
    task automatic step(input bit v, input bit ctl, input logic [2:0] bt, input bit z,
                        input bit s, input logic [31:0] tgt, input bit st, input bit rn);
        m_valid = v; m_ctlout = ctl; br_type = bt; zero = z; sign = s;
        target = tgt; stall = st; rst_n = rn;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic br(input logic [2:0] bt, input bit z, input bit s, input logic [31:0] tgt);
        step(1, 1, bt, z, s, tgt, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, BR_EQ, 0, 0, 32'h0, 0, 1);
    endtask

    task automatic do_reset();
        step(0, 0, BR_EQ, 0, 0, 32'h0, 0, 0);
        step(0, 0, BR_EQ, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        do_reset();
        check("rst.A.flush", 64'(bus_a.flush), 64'd0);
        check("rst.A.br_resolved", 64'(bus_a.br_resolved), 64'd0);

        // Taken BEQ: one-cycle redirect, three squash slots
        br(BR_EQ, 1, 0, 32'h0040_0020);
        check("beq.PCSrc", 64'(bus_a.PCSrc), 64'd1);
        check("beq.pc_target", 64'(bus_a.pc_target), 64'h0040_0020);
        check("beq.flush1", 64'(bus_a.flush), 64'd1);
        idle(1);
        check("beq.PCSrc_off", 64'(bus_a.PCSrc), 64'd0);
        check("beq.flush2", 64'(bus_a.flush), 64'd1);
        idle(1);
        check("beq.flush3", 64'(bus_a.flush), 64'd1);
        idle(1);
        check("beq.flush_end", 64'(bus_a.flush), 64'd0);
        check("beq.target_hold", 64'(bus_a.pc_target), 64'h0040_0020);

        // BNE with zero set: resolved, not taken
        do_reset();
        br(BR_NE, 1, 0, 32'h0000_1000);
        check("bne.PCSrc", 64'(bus_a.PCSrc), 64'd0);
        check("bne.flush", 64'(bus_a.flush), 64'd0);
        check("bne.resolved", 64'(bus_a.br_resolved), 64'd1);
        check("bne.taken", 64'(bus_a.br_taken), 64'd0);

        // Taken BGTZ followed by a wrong-path taken BEQ
        do_reset();
        br(BR_GTZ, 0, 0, 32'h0000_2000);
        br(BR_EQ, 1, 0, 32'h0000_3000);
        check("wp.PCSrc", 64'(bus_a.PCSrc), 64'd0);
        check("wp.target", 64'(bus_a.pc_target), 64'h0000_2000);
        idle(3);
        check("wp.taken", 64'(bus_a.br_taken), 64'd1);

        // Stall inside the squash window stretches flush by one cycle
        do_reset();
        br(BR_ALWAYS, 0, 0, 32'h0000_4000);
        idle(1);
        step(0, 0, BR_EQ, 0, 0, 32'h0, 1, 1);
        idle(1);
        check("stall.flushT4", 64'(bus_a.flush), 64'd1);
        idle(1);
        check("stall.flushT5", 64'(bus_a.flush), 64'd0);

        // Stalled branch resolves once re-presented unstalled
        step(1, 1, BR_EQ, 1, 0, 32'h0000_5000, 1, 1);
        check("stalled.PCSrc", 64'(bus_a.PCSrc), 64'd0);
        br(BR_EQ, 1, 0, 32'h0000_5000);
        check("stalled.resolve", 64'(bus_a.PCSrc), 64'd1);
        idle(3);

        // Legacy instance: BLTZ is not taken and sets sticky illegal
        do_reset();
        br(BR_LTZ, 0, 1, 32'h0000_6000);
        check("legacy.PCSrc", 64'(bus_b.PCSrc), 64'd0);
        check("legacy.illegal", 64'(bus_b.illegal_br), 64'd1);
        check("ext.A.PCSrc", 64'(bus_a.PCSrc), 64'd1);
        idle(4);
        check("legacy.sticky", 64'(bus_b.illegal_br), 64'd1);

        // Two-bit stats saturate
        do_reset();
        for (int k = 0; k < 5; k++) begin
            br(BR_EQ, 1, 0, 32'h0000_7000 + 32'(k));
            idle(3);
        end
        check("sat.B.taken", 64'(bus_b.br_taken), 64'd3);
        check("sat.B.resolved", 64'(bus_b.br_resolved), 64'd3);
        check("sat.A.taken", 64'(bus_a.br_taken), 64'd5);

        // Reset during squash, with a reserved code seen first
        br(BR_RSVD, 0, 0, 32'h0);
        br(BR_ALWAYS, 0, 0, 32'h0000_8000);
        idle(1);
        step(1, 1, BR_ALWAYS, 0, 0, 32'h0000_9000, 0, 0);
        check("rstsq.flush", 64'(bus_a.flush), 64'd0);
        check("rstsq.PCSrc", 64'(bus_a.PCSrc), 64'd0);
        check("rstsq.taken", 64'(bus_a.br_taken), 64'd0);
        check("rstsq.illegal", 64'(bus_a.illegal_br), 64'd0);
        idle(1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
